// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with a 2-flop input synchronizer, a first-word-fall-through
// byte FIFO and sticky overrun / framing-error flags.
module uart_rx_buf #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  input  logic              pop,
  input  logic              clr_err,
  output logic [7:0]        rxdata,
  output logic              rx_valid,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  output logic              frame_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]  LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic              r_sync1, r_rxs;
  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_baud, w_baud;
  logic [2:0]        r_bit, w_bit;
  logic [7:0]        r_shift;
  logic              w_shift_en, w_push, w_ferr;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overrun, r_frame_err;
  logic              w_pop_ok, w_full, w_wr, w_ovr;

  // Sync flops reset to 1 so an idle line is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_baud     = r_baud;
    w_bit      = r_bit;
    w_shift_en = 1'b0;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rxs) begin
          w_state = START;
          w_baud  = HALF_LOAD;
        end
      end
      START: begin
        if (r_baud == '0) begin
          if (!r_rxs) begin
            w_state = DATA;
            w_baud  = FULL_LOAD;
            w_bit   = 3'd0;
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_baud = r_baud - CNT_W'(1);
        end
      end
      DATA: begin
        if (r_baud == '0) begin
          w_shift_en = 1'b1;
          w_baud     = FULL_LOAD;
          w_bit      = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state = STOP;
        end else begin
          w_baud = r_baud - CNT_W'(1);
        end
      end
      STOP: begin
        // Leave at mid-stop so the next start edge is caught back-to-back.
        if (r_baud == '0) begin
          w_state = IDLE;
          if (r_rxs) w_push = 1'b1;
          else       w_ferr = 1'b1;
        end else begin
          w_baud = r_baud - CNT_W'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift <= {r_rxs, r_shift[7:1]};
  end

  assign w_pop_ok = pop && rx_valid;
  assign w_full   = (r_level == LEVEL_FULL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr     = w_push && (!w_full || w_pop_ok);
  assign w_ovr    = w_push && w_full && !w_pop_ok;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)     r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr, w_pop_ok})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Set takes priority over clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr)        r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (w_ferr)       r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
    end
  end

  assign rx_valid  = (r_level != '0);
  assign rxdata    = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign level     = r_level;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf: 16 clocks per bit, 4-entry FIFO.
module tb_uart_rx_buf;

  localparam int CPB = 16;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rxd = 1'b1;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    rxdata;
  logic          rx_valid;
  logic [AW:0]   level;
  logic          overrun;
  logic          frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int t_valid;

  uart_rx_buf #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .pop(pop), .clr_err(clr_err),
    .rxdata(rxdata), .rx_valid(rx_valid), .level(level),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame starting at a falling clock edge. pop_at pulses pop
  // for one cycle at that offset; rst_at pulses rstn low and idles the line
  // from that offset on. t_valid records the first offset rx_valid is seen.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input int pop_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    t_valid = -1;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (rst_at >= 0 && k >= rst_at) rxd = 1'b1;
      else                            rxd = bits[k / CPB];
      pop  = (k == pop_at);
      rstn = !(k == rst_at);
      @(negedge clk);
      if (rx_valid && t_valid < 0) t_valid = k + 1;
    end
    pop  = 1'b0;
    rstn = 1'b1;
    rxd  = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rxdata, exp);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_valid", rx_valid, 0);
    check("idle_level", level, 0);
    check("idle_data", rxdata, 8'h00);
    check("idle_ovr", overrun, 0);
    check("idle_ferr", frame_err, 0);

    send_frame(8'hA5, 1'b1, -1, -1);
    check("a5_latency", (t_valid >= 150 && t_valid <= 156), 1);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rxdata, 8'hA5);
    check("a5_level", level, 1);
    pop_check("a5_head", 8'hA5);
    check("a5_pop_valid", rx_valid, 0);
    check("a5_pop_data", rxdata, 8'h00);

    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, -1, -1);
    send_frame(8'h81, 1'b1, -1, -1);
    check("b2b_level", level, 4);
    pop_check("b2b_0", 8'h00);
    pop_check("b2b_1", 8'hFF);
    pop_check("b2b_2", 8'h3C);
    pop_check("b2b_3", 8'h81);
    pop_check("b2b_empty_data", 8'h00);
    check("b2b_empty_level", level, 0);
    check("b2b_empty_valid", rx_valid, 0);

    send_frame(8'h01, 1'b1, -1, -1);
    send_frame(8'h02, 1'b1, -1, -1);
    send_frame(8'h03, 1'b1, -1, -1);
    send_frame(8'h04, 1'b1, -1, -1);
    check("ovr_pre", overrun, 0);
    send_frame(8'h55, 1'b1, -1, -1);
    check("ovr_flag", overrun, 1);
    check("ovr_level", level, 4);
    pop_check("ovr_c0", 8'h01);
    pop_check("ovr_c1", 8'h02);
    pop_check("ovr_c2", 8'h03);
    pop_check("ovr_c3", 8'h04);

    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    send_frame(8'h33, 1'b1, -1, -1);
    send_frame(8'h44, 1'b1, -1, -1);
    send_frame(8'h66, 1'b1, 9 * CPB + 10, -1);
    check("pp_level", level, 4);
    check("pp_ovr", overrun, 1);
    pop_check("pp_c0", 8'h22);
    pop_check("pp_c1", 8'h33);
    pop_check("pp_c2", 8'h44);
    pop_check("pp_c3", 8'h66);
    pulse_clr();
    check("ovr_clr", overrun, 0);

    send_frame(8'h12, 1'b0, -1, -1);
    repeat (CPB) @(negedge clk);
    check("ferr_flag", frame_err, 1);
    check("ferr_level", level, 0);
    pulse_clr();
    check("ferr_clr", frame_err, 0);

    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_level", level, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", frame_err, 0);
    check("glitch_ovr", overrun, 0);

    send_frame(8'h77, 1'b1, -1, 60);
    repeat (40) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_valid", rx_valid, 0);
    send_frame(8'h34, 1'b1, -1, -1);
    repeat (40) @(negedge clk);
    check("rst_after_level", level, 1);
    check("rst_after_data", rxdata, 8'h34);
    check("rst_after_ferr", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
